// File: rtl/mux_pipe_n1.sv
// Two-stage pipelined 2^SEL_W:1 word selector with valid/ready flow control.
// Stage 1 picks one word per group, stage 2 picks the group; disabled channels are flagged and zeroed.
module mux_pipe_n1 #(
  parameter int WIDTH   = 32,
  parameter int SEL_W   = 4,
  parameter int GROUP_W = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [(1<<SEL_W)*WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]                in_sel,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [(1<<SEL_W)-1:0]           ch_en,
  output logic [WIDTH-1:0]                out_data,
  output logic [SEL_W-1:0]                out_sel,
  output logic                            out_err,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [7:0]                      err_cnt
);

  localparam int HI_W = SEL_W - GROUP_W;
  localparam int NG   = 1 << HI_W;

  logic [WIDTH-1:0] s1_grp_q [NG];
  logic [WIDTH-1:0] s1_grp_d [NG];
  logic [SEL_W-1:0] s1_sel_q, s1_sel_d;
  logic             s1_err_q, s1_err_d;
  logic             s1_valid_q, s1_valid_d;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             in_xfer, out_xfer, s2_ready, s1_adv;
  logic [WIDTH-1:0] s2_word;

  assign s2_ready = ~out_valid_q | out_ready;
  assign in_ready = rst_n & (~s1_valid_q | s2_ready);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;
  assign s1_adv   = s1_valid_q & s2_ready;

  // Each group register takes the channel sharing the low select bits within that group.
  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam logic [HI_W-1:0] GRP = HI_W'(gi);
      logic [SEL_W-1:0] ch_idx;
      assign ch_idx       = {GRP, in_sel[GROUP_W-1:0]};
      assign s1_grp_d[gi] = in_data[int'(ch_idx)*WIDTH +: WIDTH];
    end
  endgenerate

  assign s2_word = s1_grp_q[s1_sel_q[SEL_W-1:GROUP_W]];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sel_d   = s1_sel_q;
    s1_err_d   = s1_err_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_sel_d   = in_sel;
      s1_err_d   = ~ch_en[in_sel];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_data_d  = s1_err_q ? '0 : s2_word;
      out_sel_d   = s1_sel_q;
      out_err_d   = s1_err_q;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_xfer && out_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Group words carry no control meaning, so they are only load-enabled.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      for (int g = 0; g < NG; g++) begin
        s1_grp_q[g] <= s1_grp_d[g];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sel_q    <= '0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sel_q    <= s1_sel_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/mux_pipe_n1.md
Name: mux_pipe_n1

Overview:
Parametrised, pipelined N:1 word selector for the MIPS32 datapath; it generalises the fixed 16:1 combinational selector to 2^SEL_W channels of WIDTH bits. It uses a two-stage registered tree: stage 1 selects within groups, stage 2 selects the group. Valid/ready flow control lets it sit between pipeline stages under backpressure. A per-channel enable mask flags and zeroes selections of disabled channels, and a saturating counter tracks them.

Parameters:
WIDTH, 32, data word width in bits (>=1)
SEL_W, 4, select width; channel count N = 2^SEL_W (SEL_W >= 2)
GROUP_W, 3, stage-1 group select width; group size 2^GROUP_W, group count 2^(SEL_W-GROUP_W) (1 <= GROUP_W < SEL_W)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  N*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH]
in_sel  input  SEL_W  channel index
in_valid  input  1  input word/select valid
in_ready  output  1  block accepts input this cycle
ch_en  input  N  channel enable mask, sampled with the input transfer
out_data  output  WIDTH  selected word (registered)
out_sel  output  SEL_W  channel index that produced out_data
out_err  output  1  selected channel was disabled; out_data is 0
out_valid  output  1  output valid
out_ready  input  1  downstream accepts output
err_cnt  output  8  saturating count of delivered errored outputs

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n low, immediate): all stage valids = 0, out_valid = 0, out_data = 0, out_sel = 0, out_err = 0, err_cnt = 0.
- in_ready is forced to 0 while rst_n is low. Any in-flight words are discarded by reset.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 registers, loaded on an input transfer:
  - s1_grp[g] = channel {g, in_sel[GROUP_W-1:0]} for every group g.
  - s1_sel = in_sel.
  - s1_err = ~ch_en[in_sel].
  - s1_valid = 1.
- Stage 2 registers (outputs), loaded when s1_valid && s2_ready:
  - out_data = s1_err ? 0 : s1_grp[s1_sel[SEL_W-1:GROUP_W]].
  - out_sel = s1_sel, out_err = s1_err, out_valid = 1.
- Ready chain (combinational):
  - s2_ready = ~out_valid | out_ready.
  - in_ready = rst_n & (~s1_valid | s2_ready).
- Valid clearing:
  - s1_valid clears when stage 1 moves to stage 2 with no new input transfer in the same cycle.
  - out_valid clears on an output transfer when stage 1 has nothing to move.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 word per cycle when out_ready is held high.
- Under stall (out_valid && !out_ready), out_data, out_sel and out_err hold stable. Stage 1 holds if also full. At most 2 words are in flight.
- Simultaneous input transfer and stage-1 advance in one cycle: stage 1 takes the new word; no bubble and no loss.
- err_cnt increments by 1 on each output transfer with out_err = 1. It saturates at 255; no wrap.
- in_data, in_sel and ch_en are don't-care when no input transfer occurs. Only values captured at the transfer matter.
- No combinational path from in_data or in_sel to out_data.

Test Plan:
- Reset then stream: channel k = 32'h1000_0000+k, ch_en = 16'hFFFF, out_ready = 1, in_sel = 0..15 on consecutive cycles -> out_data = 32'h1000_0000..32'h1000_000F in order, first at 2 cycles after the first transfer, out_valid continuous for 16 cycles, out_err = 0.
- Group boundaries: in_sel = 7, 8, 15, 0 -> out_data = ch7, ch8, ch15, ch0, with out_sel matching.
- Backpressure: out_ready = 0 after 1 output, keep feeding -> in_ready drops after 2 words held; out_data stable for 5 stalled cycles; release -> all 3 words delivered in order, none duplicated.
- Disabled channel: ch_en = 16'hFFDF, in_sel = 5 -> out_err = 1, out_data = 0, err_cnt = 1; in_sel = 6 next -> out_err = 0, out_data = ch6.
- Saturation: 260 errored transfers -> err_cnt = 255.
- Reset mid-flight: 2 words in flight, out_ready = 0, pulse rst_n low mid-cycle -> out_valid = 0 and err_cnt = 0 immediately, in_ready = 0 while low, 1 after release; no stale word emerges.
- Parameter sweep: WIDTH = 8, SEL_W = 3, GROUP_W = 1 -> same stream check across 8 channels.
